// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types and constants for the RV32M multiply/divide
//                sequencer (op encodings, FSM states, special results).
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

   // funct3 encodings of the M-extension ops
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   // Sequencer states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } muldiv_state_e;

   localparam int          C_STEPS    = 32;
   localparam logic [31:0] C_ALL_ONES = 32'hFFFF_FFFF;
   localparam logic [31:0] C_INT_MIN  = 32'h8000_0000;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_addsub
//  Description : Combinational 33-bit add/subtract with carry-out, shared by
//                the multiply (add) and restoring-divide (subtract) steps.
//                On subtract, carry-out high means "no borrow".
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_addsub (
   input  logic [32:0] i_a,
   input  logic [32:0] i_b,
   input  logic        i_sub,
   output logic [32:0] o_sum,
   output logic        o_carry
);

   logic [32:0] w_b;

   assign w_b = i_sub ? ~i_b : i_b;
   assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {33'b0, i_sub};

endmodule : muldiv_addsub
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative RV32M multiply/divide sequencer. 32-step shift-add
//                multiply and restoring divide over a shared 33-bit add/sub,
//                with sign fix-up and divide special cases.
//                Build option MULDIV_FAST_ZERO_EN: zero multiply operands,
//                divide by zero and signed overflow skip the step loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   input  logic            flush,
   output logic            busy,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_result
);

   muldiv_state_e   r_state, w_next;
   muldiv_op_e      r_op;
   logic [5:0]      r_cnt;
   logic [2*XLEN-1:0] r_prod;     // product; low half doubles as dividend/quotient
   logic [XLEN-1:0] r_opb;        // multiplicand or divisor magnitude
   logic [XLEN-1:0] r_rem;        // partial remainder
   logic [XLEN-1:0] r_a_raw;      // original rs1, returned by REM on divide by zero
   logic [XLEN-1:0] r_fix;        // result computed in FIX, presented in DONE
   logic [XLEN-1:0] r_result;     // held result between responses
   logic            r_neg_res, r_neg_rem, r_dz, r_ovf;

   logic            w_accept, w_sa, w_sb, w_dz, w_ovf, w_fast;
   logic [XLEN-1:0] w_mag_a, w_mag_b;
   logic [XLEN:0]   w_shift, w_as_a, w_as_b, w_sum;
   logic            w_carry, w_is_div;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0] w_quo_s, w_rem_s, w_fix_res;

   // ---------------- request decode ----------------
   assign w_accept = req_valid && (r_state == S_IDLE) && !flush;
   assign w_sa     = (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                     (req_op == OP_DIV)  || (req_op == OP_REM);
   assign w_sb     = (req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM);
   assign w_mag_a  = (w_sa && req_a[XLEN-1]) ? -req_a : req_a;
   assign w_mag_b  = (w_sb && req_b[XLEN-1]) ? -req_b : req_b;
   assign w_dz     = req_op[2] && (req_b == '0);
   assign w_ovf    = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                     (req_a == C_INT_MIN) && (req_b == C_ALL_ONES);

`ifdef MULDIV_FAST_ZERO_EN
   assign w_fast = (!req_op[2] && ((req_a == '0) || (req_b == '0))) || w_dz || w_ovf;
`else
   assign w_fast = 1'b0;
`endif

   // ---------------- shared step datapath ----------------
   assign w_is_div = r_op[2];
   assign w_shift  = {r_rem, r_prod[XLEN-1]};
   assign w_as_a   = w_is_div ? w_shift : {1'b0, r_prod[2*XLEN-1:XLEN]};
   assign w_as_b   = {1'b0, r_opb};

   muldiv_addsub u_addsub (
      .i_a     (w_as_a),
      .i_b     (w_as_b),
      .i_sub   (w_is_div),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   // ---------------- sign fix-up and result select ----------------
   assign w_prod_s = r_neg_res ? -r_prod : r_prod;
   assign w_quo_s  = r_neg_res ? -r_prod[XLEN-1:0] : r_prod[XLEN-1:0];
   assign w_rem_s  = r_neg_rem ? -r_rem : r_rem;

   // Select the final result; special divide cases override the loop output
   always_comb begin
      w_fix_res = '0;
      case (r_op)
         OP_MUL:                         w_fix_res = w_prod_s[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:   w_fix_res = w_prod_s[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:                w_fix_res = w_quo_s;
         default:                        w_fix_res = w_rem_s;
      endcase
      if (r_dz)
         w_fix_res = r_op[1] ? r_a_raw : C_ALL_ONES;
      else if (r_ovf)
         w_fix_res = r_op[1] ? '0 : C_INT_MIN;
   end

   // ---------------- FSM ----------------
   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; flush overrides every transition
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_fast ? S_FIX : S_CALC;
         S_CALC:  if (r_cnt == 6'(C_STEPS - 1)) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (flush) w_next = S_IDLE;
   end

   // Operand capture, iteration steps and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op      <= OP_MUL;
         r_cnt     <= '0;
         r_prod    <= '0;
         r_opb     <= '0;
         r_rem     <= '0;
         r_a_raw   <= '0;
         r_fix     <= '0;
         r_result  <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_dz      <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op      <= muldiv_op_e'(req_op);
            r_cnt     <= '0;
            r_prod    <= w_fast ? '0 : {{XLEN{1'b0}}, w_mag_a};
            r_opb     <= w_mag_b;
            r_rem     <= '0;
            r_a_raw   <= req_a;
            r_neg_res <= (w_sa & req_a[XLEN-1]) ^ (w_sb & req_b[XLEN-1]);
            r_neg_rem <= w_sa & req_a[XLEN-1];
            r_dz      <= w_dz;
            r_ovf     <= w_ovf;
         end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 6'd1;
            if (w_is_div) begin
               // restoring step: keep the difference only when it did not borrow
               r_rem              <= w_carry ? w_sum[XLEN-1:0] : w_shift[XLEN-1:0];
               r_prod[XLEN-1:0]   <= {r_prod[XLEN-2:0], w_carry};
            end else if (r_prod[0]) begin
               r_prod <= {w_sum, r_prod[XLEN-1:1]};
            end else begin
               r_prod <= {1'b0, r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1:1]};
            end
         end else if ((r_state == S_FIX) && !flush) begin
            r_fix <= w_fix_res;
         end
         if ((r_state == S_DONE) && !flush)
            r_result <= r_fix;
      end
   end

   assign req_ready   = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign resp_valid  = (r_state == S_DONE) && !flush;
   assign resp_result = resp_valid ? r_fix : r_result;

endmodule : muldiv_seq
`default_nettype wire
